// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-through, no-write-allocate data cache
// sitting between the CPU memory stage and data_mem. One 32-bit word per line.
// Read misses stall for two cycles (miss-detect cycle + FILL cycle).
// Optional build macro DCACHE_STATS_EN adds hit_count / miss_count outputs.
//
// Handshake: the CPU presents a/re/we/memcontrol for a cycle; while stall is
// high it must hold a/re/memcontrol stable, and the access completes in the
// first cycle that stall is low.
module dcache_direct #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int INDEX_BITS    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] a,
    input  logic                     re,
    input  logic                     we,
    input  logic [DATA_WIDTH-1:0]    writedata,
    input  logic [2:0]               memcontrol,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    readdata,
    output logic                     stall,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_writedata,
    output logic [2:0]               mem_memcontrol,
    input  logic [DATA_WIDTH-1:0]    mem_readdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDRESS_WIDTH - INDEX_BITS - 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    // Line storage
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES];
    logic [0:0]            r_state;

    // Address decode and lookup
    logic [1:0]            w_offset;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [DATA_WIDTH-1:0] w_line;
    logic                  w_hit;
    logic                  w_idle;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_rd_hit;
    logic                  w_rd_miss;
    logic                  w_code_ok;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_offset = a[1:0];
    assign w_index  = a[INDEX_BITS+1:2];
    assign w_tag    = a[ADDRESS_WIDTH-1:INDEX_BITS+2];
    assign w_line   = r_data[w_index];
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);

    // A write takes priority over a read; flush forces a concurrent read to miss.
    assign w_idle    = (r_state == S_IDLE);
    assign w_wr      = w_idle && we && !rst;
    assign w_rd      = w_idle && re && !we && !rst;
    assign w_rd_hit  = w_rd && w_hit && !flush;
    assign w_rd_miss = w_rd && !(w_hit && !flush);
    assign w_code_ok = (memcontrol == 3'b000) || (memcontrol == 3'b001) ||
                       (memcontrol == 3'b010);

    // Stall on a detected miss and throughout FILL; reset always releases it.
    assign stall = !rst && ((r_state == S_FILL) || w_rd_miss);

    // Load extraction from the cached word (offset 0 is the most significant byte)
    always_comb begin
        w_byte = 8'h00;
        case (w_offset)
            2'd0:    w_byte = w_line[31:24];
            2'd1:    w_byte = w_line[23:16];
            2'd2:    w_byte = w_line[15:8];
            default: w_byte = w_line[7:0];
        endcase
        w_half = a[1] ? w_line[15:0] : w_line[31:16];
        w_ext  = 32'hdeadbeef;
        case (memcontrol)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'h000000, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'h0000, w_half};
            3'b010:  w_ext = w_line;
            default: w_ext = 32'hdeadbeef;
        endcase
        readdata = re ? w_ext : '0;
    end

    // Store merge: replace only the bytes data_mem would write
    always_comb begin
        w_merged = w_line;
        case (memcontrol)
            3'b000: begin
                case (w_offset)
                    2'd0:    w_merged[31:24] = writedata[7:0];
                    2'd1:    w_merged[23:16] = writedata[7:0];
                    2'd2:    w_merged[15:8]  = writedata[7:0];
                    default: w_merged[7:0]   = writedata[7:0];
                endcase
            end
            3'b001: begin
                if (a[1]) w_merged[15:0]  = writedata[15:0];
                else      w_merged[31:16] = writedata[15:0];
            end
            3'b010:  w_merged = writedata;
            default: w_merged = w_line;
        endcase
    end

    // data_mem bus: writes go straight through, FILL fetches the aligned word
    always_comb begin
        mem_we         = 1'b0;
        mem_a          = a;
        mem_memcontrol = 3'b010;
        mem_writedata  = writedata;
        if (r_state == S_FILL) begin
            mem_a = {a[ADDRESS_WIDTH-1:2], 2'b00};
        end else if (w_wr) begin
            mem_we         = 1'b1;
            mem_memcontrol = memcontrol;
        end
    end

    // FSM and valid bits: reset/flush clear, FILL validates, odd-size store hit invalidates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_valid <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (w_wr && w_hit && !w_code_ok) begin
                        r_valid[w_index] <= 1'b0;
                    end
                    if (w_rd_miss) begin
                        r_state <= S_FILL;
                    end
                end
                default: begin
                    r_valid[w_index] <= 1'b1;
                    r_state          <= S_IDLE;
                end
            endcase
        end
    end

    // Line data and tag: loaded on FILL, patched by store hits
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_FILL) begin
                r_data[w_index] <= mem_readdata;
                r_tag[w_index]  <= w_tag;
            end else if (w_wr && w_hit && w_code_ok) begin
                r_data[w_index] <= w_merged;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Hit/miss counters, cleared by reset or an accepted flush
    always_ff @(posedge clk) begin
        if (rst || (w_idle && flush)) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_rd_hit)  r_hit_count  <= r_hit_count + 32'd1;
            if (w_rd_miss) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// tb_dcache_direct: directed + random checks of dcache_direct against a
// reference memory image and a resident-address table per cache index.
module tb_dcache_direct;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic        re;
    logic        we;
    logic [31:0] writedata;
    logic [2:0]  memcontrol;
    logic        flush;
    logic [31:0] readdata;
    logic        stall;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_writedata;
    logic [2:0]  mem_memcontrol;
    logic [31:0] mem_readdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    // Environment data_mem image and the bench's own reference image
    logic [31:0] dmem    [0:1023];
    logic [31:0] ref_mem [0:1023];
    // Which aligned address each cache index is expected to hold
    logic        res_valid [0:15];
    logic [31:0] res_addr  [0:15];

    int checks = 0;
    int fails  = 0;

    dcache_direct dut (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .re             (re),
        .we             (we),
        .writedata      (writedata),
        .memcontrol     (memcontrol),
        .flush          (flush),
        .readdata       (readdata),
        .stall          (stall),
        .mem_a          (mem_a),
        .mem_we         (mem_we),
        .mem_writedata  (mem_writedata),
        .mem_memcontrol (mem_memcontrol),
        .mem_readdata   (mem_readdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    assign mem_readdata = dmem[mem_a[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected load result from a memory word using shift/mask arithmetic
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] code);
        int unsigned o;
        int unsigned b;
        int unsigned h;
        o = off;
        b = (w >> (8 * (3 - o))) & 32'hFF;
        h = (w >> (16 * (1 - (o / 2)))) & 32'hFFFF;
        case (code)
            3'b000:  return (b >= 128) ? (b + 32'hFFFFFF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? (h + 32'hFFFF0000) : h;
            3'b101:  return h;
            3'b010:  return w;
            default: return 32'hdeadbeef;
        endcase
    endfunction

    // Expected memory word after a store
    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] off,
                                                input logic [2:0] code, input logic [31:0] d);
        int unsigned o;
        int unsigned sh;
        logic [31:0] m;
        o = off;
        case (code)
            3'b000: begin
                sh = 8 * (3 - o);
                m  = 32'hFF << sh;
                return (w & ~m) | ((d & 32'hFF) << sh);
            end
            3'b001: begin
                sh = 16 * (1 - (o / 2));
                m  = 32'hFFFF << sh;
                return (w & ~m) | ((d & 32'hFFFF) << sh);
            end
            3'b010:  return d;
            default: return w;
        endcase
    endfunction

    // data_mem behaviour for a write request seen on the bus
    task automatic env_write(input logic [31:0] ad, input logic [2:0] code, input logic [31:0] d);
        logic [31:0] w;
        w = dmem[ad[11:2]];
        case (code)
            3'b000: begin
                case (ad[1:0])
                    2'd0:    w[31:24] = d[7:0];
                    2'd1:    w[23:16] = d[7:0];
                    2'd2:    w[15:8]  = d[7:0];
                    default: w[7:0]   = d[7:0];
                endcase
            end
            3'b001: begin
                if (ad[1]) w[15:0]  = d[15:0];
                else       w[31:16] = d[15:0];
            end
            3'b010:  w = d;
            default: w = dmem[ad[11:2]];
        endcase
        dmem[ad[11:2]] = w;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) res_valid[i] = 1'b0;
    endtask

    // One load; counts stall cycles and checks result once stall drops
    task automatic do_load(input logic [31:0] addr, input logic [2:0] code,
                           input logic with_flush, input string tag);
        int          cyc;
        int          idx;
        logic        hit;
        logic [31:0] exp;
        logic [31:0] al;
        idx = int'(addr[5:2]);
        al  = {addr[31:2], 2'b00};
        if (with_flush) model_clear();
        hit = res_valid[idx] && (res_addr[idx] == al);
        exp = model_load(ref_mem[addr[11:2]], addr[1:0], code);
        a = addr; re = 1'b1; we = 1'b0; memcontrol = code; flush = with_flush;
        cyc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!stall) break;
            if (cyc == 1) begin
                chk({tag, "_fill_mem_a"}, mem_a, al);
                chk({tag, "_fill_mem_ctl"}, {29'd0, mem_memcontrol}, 32'd2);
                chk({tag, "_fill_mem_we"}, {31'd0, mem_we}, 32'd0);
            end
            cyc++;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        chk({tag, "_stall_cycles"}, cyc, hit ? 32'd0 : 32'd2);
        chk({tag, "_readdata"}, readdata, exp);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        res_valid[idx] = 1'b1;
        res_addr[idx]  = al;
        @(posedge clk); #1;
        re = 1'b0; flush = 1'b0;
    endtask

    // One store; must pass straight through to data_mem with no stall
    task automatic do_store(input logic [31:0] addr, input logic [2:0] code,
                            input logic [31:0] d, input string tag);
        int   idx;
        logic ok;
        idx = int'(addr[5:2]);
        ok  = (code == 3'b000) || (code == 3'b001) || (code == 3'b010);
        a = addr; re = 1'b0; we = 1'b1; memcontrol = code; writedata = d; flush = 1'b0;
        @(negedge clk);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd1);
        chk({tag, "_mem_a"}, mem_a, addr);
        chk({tag, "_mem_ctl"}, {29'd0, mem_memcontrol}, {29'd0, code});
        chk({tag, "_mem_wdata"}, mem_writedata, d);
        if (mem_we) env_write(mem_a, mem_memcontrol, mem_writedata);
        if (ok) ref_mem[addr[11:2]] = model_store(ref_mem[addr[11:2]], addr[1:0], code, d);
        if (!ok && res_valid[idx] && res_addr[idx] == {addr[31:2], 2'b00}) res_valid[idx] = 1'b0;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic do_flush(input string tag);
        a = 32'h10000; re = 1'b0; we = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_idle_ctl"}, {29'd0, mem_memcontrol}, 32'd2);
        model_clear();
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        logic [2:0]  lcodes [0:6];
        logic [2:0]  scodes [0:2];
        logic [31:0] ra;
        logic [2:0]  rc;
        int          sel;

        lcodes[0] = 3'b000; lcodes[1] = 3'b100; lcodes[2] = 3'b001; lcodes[3] = 3'b101;
        lcodes[4] = 3'b010; lcodes[5] = 3'b010; lcodes[6] = 3'b011;
        scodes[0] = 3'b000; scodes[1] = 3'b001; scodes[2] = 3'b010;

        for (int i = 0; i < 1024; i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        dmem[(32'h10000 >> 2) & 1023]    = 32'hAABBCCDD;
        ref_mem[(32'h10000 >> 2) & 1023] = 32'hAABBCCDD;
        model_clear();
        for (int i = 0; i < 16; i++) res_addr[i] = 32'd0;

        // Reset
        rst = 1'b1; a = 32'h10000; re = 1'b0; we = 1'b0; writedata = 32'd0;
        memcontrol = 3'b010; flush = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("post_rst_readdata", readdata, 32'd0);
        chk("idle_mem_a", mem_a, 32'h10000);
        chk("idle_mem_ctl", {29'd0, mem_memcontrol}, 32'd2);
        @(posedge clk); #1;

        // Fill then hit
        do_load(32'h10000, 3'b010, 1'b0, "lw_miss");
        do_load(32'h10000, 3'b010, 1'b0, "lw_hit");
        do_load(32'h10001, 3'b000, 1'b0, "lb");
        do_load(32'h10001, 3'b100, 1'b0, "lbu");
        do_load(32'h10002, 3'b001, 1'b0, "lh");
        do_load(32'h10000, 3'b101, 1'b0, "lhu");

        // Store hit updates cache and memory
        do_store(32'h10003, 3'b000, 32'h00000011, "sb_hit");
        do_load(32'h10000, 3'b010, 1'b0, "lw_after_sb");
        chk("dmem_after_sb", dmem[(32'h10000 >> 2) & 1023], 32'hAABBCC11);

        // No-allocate store miss
        do_store(32'h10040, 3'b010, 32'h12345678, "sw_miss");
        do_load(32'h10040, 3'b010, 1'b0, "lw_after_sw");

        // Conflict on index 0
        do_load(32'h10000, 3'b010, 1'b0, "conflict_a");
        do_load(32'h10040, 3'b010, 1'b0, "conflict_b");
        do_load(32'h10000, 3'b010, 1'b0, "conflict_a2");

        // Reset during FILL aborts the fill
        a = 32'h10080; re = 1'b1; we = 1'b0; memcontrol = 3'b010;
        @(negedge clk);
        chk("rf_miss_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; re = 1'b0;
        @(negedge clk);
        chk("rf_in_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rf_after_stall", {31'd0, stall}, 32'd0);
        chk("rf_after_readdata", readdata, 32'd0);
        chk("rf_after_mem_we", {31'd0, mem_we}, 32'd0);
        model_clear();
        @(posedge clk); #1;
        do_load(32'h10080, 3'b010, 1'b0, "rf_lw_aborted");
        do_load(32'h10000, 3'b010, 1'b0, "rf_lw_other");

        // Flush
        do_load(32'h10004, 3'b010, 1'b0, "pre_flush");
        do_load(32'h10004, 3'b010, 1'b0, "pre_flush_hit");
        do_flush("flush");
        do_load(32'h10004, 3'b010, 1'b0, "post_flush");
        do_load(32'h10004, 3'b010, 1'b1, "flush_with_read");

        // Odd-size store hit invalidates; odd load code gives the marker
        do_store(32'h10004, 3'b011, 32'hCAFEF00D, "st_odd");
        do_load(32'h10004, 3'b010, 1'b0, "after_odd_store");
        do_load(32'h10006, 3'b011, 1'b0, "ld_odd_code");

        // Random mix
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            ra  = 32'h10000 + ($urandom_range(0, 63) << 2);
            if (sel == 0) begin
                do_flush("rnd_flush");
            end else if (sel <= 3) begin
                rc = scodes[$urandom_range(0, 2)];
                if (rc == 3'b000)      ra = ra + $urandom_range(0, 3);
                else if (rc == 3'b001) ra = ra + ($urandom_range(0, 1) * 2);
                do_store(ra, rc, $urandom, "rnd_st");
            end else begin
                rc = lcodes[$urandom_range(0, 6)];
                if (rc == 3'b000 || rc == 3'b100 || rc == 3'b011) ra = ra + $urandom_range(0, 3);
                else if (rc == 3'b001 || rc == 3'b101)            ra = ra + ($urandom_range(0, 1) * 2);
                do_load(ra, rc, 1'b0, "rnd_ld");
            end
        end

        for (int i = 0; i < 64; i++) begin
            chk("final_dmem", dmem[((32'h10000 >> 2) + i) & 1023], ref_mem[((32'h10000 >> 2) + i) & 1023]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and data_mem.
- CPU side uses the same request encoding as data_mem: address, we, writedata, memcontrol = funct3.
- Read misses stall the pipeline while one aligned word is fetched from data_mem.
- Writes always go through to data_mem in the same cycle.

Parameters:
ADDRESS_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width; fixed at 32
INDEX_BITS, 4, log2 of line count (16 lines, 1 word per line)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
a  in  ADDRESS_WIDTH  CPU byte address (ALUResult)
re  in  1  CPU load request
we  in  1  CPU store request
writedata  in  32  CPU store data
memcontrol  in  3  funct3 of the load/store
flush  in  1  invalidate all lines
readdata  out  32  load result, extended per memcontrol
stall  out  1  freeze pipeline; CPU holds a/re/memcontrol stable while high
mem_a  out  ADDRESS_WIDTH  data_mem address
mem_we  out  1  data_mem write enable
mem_writedata  out  32  data_mem write data
mem_memcontrol  out  3  data_mem funct3
mem_readdata  in  32  data_mem asynchronous read data

Behaviour:
- Address fields:
  - offset = a[1:0]
  - index = a[INDEX_BITS+1:2]
  - tag = a[ADDRESS_WIDTH-1:INDEX_BITS+2]
- Per line storage: valid bit, tag, 32-bit word.
- Word byte order matches data_mem: the byte at offset 0 is bits 31:24, offset 3 is bits 7:0.
  - Half at a[1]=0 is bits 31:16; half at a[1]=1 is bits 15:0.
- FSM states: IDLE, FILL.
- Reset (rst=1 at a clock edge):
  - state=IDLE, all valid=0.
  - Outputs during and after reset: stall=0, mem_we=0, readdata=0 while re=0.
- IDLE, re=1 and hit (valid and tag match):
  - readdata combinational, same cycle; stall=0.
  - Extraction from the cached word:
    - 000 = sign-extended byte
    - 100 = zero-extended byte
    - 001 = sign-extended half
    - 101 = zero-extended half
    - 010 = word
    - other codes = 32'hdeadbeef
- IDLE, re=1 and miss: stall=1 combinationally; next state FILL.
- FILL:
  - stall=1.
  - mem_a = {a[ADDRESS_WIDTH-1:2],2'b00}, mem_memcontrol=010, mem_we=0.
  - At the edge, line[index] takes word=mem_readdata, tag, valid=1; next state IDLE.
  - The following cycle hits with stall=0. Miss penalty = 2 stall cycles.
- IDLE, we=1 (we has priority over re):
  - mem_we=1, mem_a=a, mem_memcontrol=memcontrol, mem_writedata=writedata, stall=0.
  - Hit with code 000/001/010: only the addressed bytes of the cached word update at the edge (half/word alignment masks as data_mem).
  - Hit with any other code: the line is invalidated.
  - Miss: cache unchanged (no allocate).
- Idle bus: when no access, mem_we=0, mem_a=a, mem_memcontrol=010.
- flush=1 in IDLE: all valid cleared at the edge. A simultaneous read is treated as a miss; a simultaneous write still goes to memory.
- flush=1 in FILL: ignored until the return to IDLE.
- Reset during FILL: abort; the line is not written, state=IDLE, all invalid.
- readdata is don't-care while stall=1; the bench must not check it.

Optional Feature:
DCACHE_STATS_EN
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each IDLE read hit with stall=0.
  - miss_count increments on each IDLE→FILL transition.
  - Both wrap at 2^32 and clear on rst or flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then lw a=0x10000 with data_mem word 0xAABBCCDD → stall=1 for 2 cycles; then readdata=0xAABBCCDD, stall=0; repeat → hit, 0 stall cycles.
- After fill, lb a=0x10001 → 0xFFFFFFBB; lbu a=0x10001 → 0x000000BB; lh a=0x10002 → 0xFFFFCCDD; lhu a=0x10000 → 0x0000AABB.
- sb 0x11 to a=0x10003 on a cached line → mem_we=1 same cycle; next lw 0x10000 hits and returns 0xAABBCC11; data_mem also holds 0x11.
- sw 0x12345678 to uncached a=0x10040 → written through with no stall; next lw 0x10040 misses (2 stall cycles) and returns 0x12345678.
- Conflict: lw 0x10000 then lw 0x10040 (same index 0, different tag) → second access misses; lw 0x10000 again → misses again.
- rst asserted in the FILL cycle → next cycle state IDLE, stall=0 with re=0; lw 0x10000 → misses. Also: flush asserted → next read of a cached address misses.
